// File: rtl/mipi_tx_pkg.sv
// Shared types and line encodings for the MIPI D-PHY high-speed transmit sequencer.
package mipi_tx_pkg;

   typedef enum logic [2:0] {
      ST_STOP,
      ST_HS_RQST,
      ST_HS_PREP,
      ST_HS_ZERO,
      ST_HS_SYNC,
      ST_HS_DATA,
      ST_HS_TRAIL,
      ST_HS_EXIT
   } state_e;

   localparam logic [7:0] SYNC_WORD = 8'hB8;

   // LP line encodings, packed as {dp, dn}
   localparam logic [1:0] LP_11 = 2'b11;
   localparam logic [1:0] LP_01 = 2'b01;
   localparam logic [1:0] LP_00 = 2'b00;

endpackage

// File: rtl/mipi_tx_timer.sv
// Loadable 8-bit down-counter; holds at zero and flags it, shared by all timed states.
module mipi_tx_timer (
   input  logic       clk_in_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   output logic       zero_o
);

   logic [7:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != 8'd0) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk_in_i) begin
      if (!rst_ni) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == 8'd0);

endmodule

// File: rtl/mipi_tx_hs_seq.sv
// D-PHY data-lane HS burst sequencer: LP-11 -> LP-01 -> LP-00 -> HS-zero/sync/data/trail -> LP-11.
//
// state       | meaning
// ST_STOP     | LP-11 idle, waits for request with PLL locked
// ST_HS_RQST  | LP-01 for T_LPX cycles
// ST_HS_PREP  | LP-00 for T_PREPARE cycles
// ST_HS_ZERO  | HS 0x00 words for T_ZERO cycles
// ST_HS_SYNC  | HS sync word, first byte accepted
// ST_HS_DATA  | payload bytes, one per cycle
// ST_HS_TRAIL | inverted last bit held for T_TRAIL cycles
// ST_HS_EXIT  | LP-11 hold for T_EXIT cycles, requests ignored
module mipi_tx_hs_seq
   import mipi_tx_pkg::*;
#(
   parameter int T_LPX     = 4,
   parameter int T_PREPARE = 3,
   parameter int T_ZERO    = 6,
   parameter int T_TRAIL   = 4,
   parameter int T_EXIT    = 8
) (
   input  logic       clk_in_i,
   input  logic       rst_ni,
   input  logic       pll_lock_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   input  logic       tx_last_i,
   output logic       tx_ready_o,
   output logic [7:0] hs_tx_data_o,
   output logic       hs_en_o,
   output logic       lp_en_o,
   output logic       tx_oe_o,
   output logic       lp_tx_dp_o,
   output logic       lp_tx_dn_o,
   output logic       busy_o,
   output logic       underflow_o,
   output logic       abort_o
);

   if (T_LPX < 1 || T_LPX > 255 || T_PREPARE < 1 || T_PREPARE > 255 ||
       T_ZERO < 1 || T_ZERO > 255 || T_TRAIL < 1 || T_TRAIL > 255 ||
       T_EXIT < 1 || T_EXIT > 255) begin : g_bad_param
      $fatal(1, "mipi_tx_hs_seq: timing parameters must lie in 1..255");
   end

   state_e     state_q, state_d;
   logic [7:0] hs_data_q, hs_data_d;
   logic [1:0] lp_q, lp_d;
   logic       hs_en_q, hs_en_d, lp_en_q, lp_en_d, oe_q, oe_d;
   logic       ready_q, ready_d, busy_q, busy_d;
   logic       uf_q, uf_d, ab_q, ab_d;
   logic       tmr_load, tmr_zero;
   logic [7:0] tmr_val;

   mipi_tx_timer u_timer (
      .clk_in_i   (clk_in_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .zero_o     (tmr_zero)
   );

   assign tmr_load = (state_d != state_q);

   always_comb begin
      tmr_val = 8'd0;
      case (state_d)
         ST_HS_RQST:  tmr_val = 8'(T_LPX - 1);
         ST_HS_PREP:  tmr_val = 8'(T_PREPARE - 1);
         ST_HS_ZERO:  tmr_val = 8'(T_ZERO - 1);
         ST_HS_TRAIL: tmr_val = 8'(T_TRAIL - 1);
         ST_HS_EXIT:  tmr_val = 8'(T_EXIT - 1);
         default:     tmr_val = 8'd0;
      endcase
   end

   always_ff @(posedge clk_in_i) begin
      if (!rst_ni) begin
         state_q   <= ST_STOP;
         hs_data_q <= 8'h00;
         lp_q      <= LP_11;
         hs_en_q   <= 1'b0;
         lp_en_q   <= 1'b1;
         oe_q      <= 1'b1;
         ready_q   <= 1'b0;
         busy_q    <= 1'b0;
         uf_q      <= 1'b0;
         ab_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         hs_data_q <= hs_data_d;
         lp_q      <= lp_d;
         hs_en_q   <= hs_en_d;
         lp_en_q   <= lp_en_d;
         oe_q      <= oe_d;
         ready_q   <= ready_d;
         busy_q    <= busy_d;
         uf_q      <= uf_d;
         ab_q      <= ab_d;
      end
   end

   always_comb begin
      state_d = state_q;
      uf_d    = 1'b0;
      ab_d    = 1'b0;
      case (state_q)
         ST_STOP:    if (tx_valid_i && pll_lock_i) state_d = ST_HS_RQST;
         ST_HS_RQST: if (tmr_zero) state_d = ST_HS_PREP;
         ST_HS_PREP: if (tmr_zero) state_d = ST_HS_ZERO;
         ST_HS_ZERO: if (tmr_zero) state_d = ST_HS_SYNC;
         ST_HS_SYNC, ST_HS_DATA: begin
            // ready low here means the last byte is on the wire now
            if (!ready_q) begin
               state_d = ST_HS_TRAIL;
            end else if (tx_valid_i) begin
               state_d = ST_HS_DATA;
            end else begin
               state_d = ST_HS_TRAIL;
               uf_d    = 1'b1;
            end
         end
         ST_HS_TRAIL: if (tmr_zero) state_d = ST_HS_EXIT;
         ST_HS_EXIT:  if (tmr_zero) state_d = ST_STOP;
         default:     state_d = ST_STOP;
      endcase
      if (state_q != ST_STOP && state_q != ST_HS_EXIT && !pll_lock_i) begin
         state_d = ST_HS_EXIT;
         uf_d    = 1'b0;
         ab_d    = 1'b1;
      end
   end

   always_comb begin
      hs_data_d = 8'h00;
      hs_en_d   = 1'b0;
      lp_d      = LP_11;
      ready_d   = 1'b0;
      case (state_d)
         ST_HS_RQST: lp_d = LP_01;
         ST_HS_PREP: lp_d = LP_00;
         ST_HS_ZERO: begin
            hs_en_d = 1'b1;
            lp_d    = LP_00;
         end
         ST_HS_SYNC: begin
            hs_en_d   = 1'b1;
            lp_d      = LP_00;
            hs_data_d = SYNC_WORD;
            ready_d   = 1'b1;
         end
         ST_HS_DATA: begin
            hs_en_d   = 1'b1;
            lp_d      = LP_00;
            hs_data_d = tx_data_i;
            ready_d   = ~tx_last_i;
         end
         ST_HS_TRAIL: begin
            hs_en_d   = 1'b1;
            lp_d      = LP_00;
            hs_data_d = (state_q == ST_HS_TRAIL) ? hs_data_q : {8{~hs_data_q[7]}};
         end
         default: lp_d = LP_11;
      endcase
      lp_en_d = ~hs_en_d;
      oe_d    = hs_en_d | lp_en_d;
      busy_d  = (state_d != ST_STOP);
   end

   assign tx_ready_o   = ready_q;
   assign hs_tx_data_o = hs_data_q;
   assign hs_en_o      = hs_en_q;
   assign lp_en_o      = lp_en_q;
   assign tx_oe_o      = oe_q;
   assign lp_tx_dp_o   = lp_q[1];
   assign lp_tx_dn_o   = lp_q[0];
   assign busy_o       = busy_q;
   assign underflow_o  = uf_q;
   assign abort_o      = ab_q;

endmodule

// File: tb/tb_mipi_tx_hs_seq.sv
// Scoreboard bench: scenarios queue per-cycle expected output snapshots, a negedge monitor pops and compares.
module tb_mipi_tx_hs_seq;

   localparam int P_LPX   = 2;
   localparam int P_PREP  = 2;
   localparam int P_ZERO  = 3;
   localparam int P_TRAIL = 4;
   localparam int P_EXIT  = 5;

   logic       clk = 1'b0;
   logic       rst_n, lock, valid, last;
   logic [7:0] data;
   logic       ready, hs_en, lp_en, oe, dp, dn, busy, uf, ab;
   logic [7:0] hs_data;

   always #5 clk = ~clk;

   mipi_tx_hs_seq #(
      .T_LPX(P_LPX), .T_PREPARE(P_PREP), .T_ZERO(P_ZERO),
      .T_TRAIL(P_TRAIL), .T_EXIT(P_EXIT)
   ) dut (
      .clk_in_i     (clk),
      .rst_ni       (rst_n),
      .pll_lock_i   (lock),
      .tx_data_i    (data),
      .tx_valid_i   (valid),
      .tx_last_i    (last),
      .tx_ready_o   (ready),
      .hs_tx_data_o (hs_data),
      .hs_en_o      (hs_en),
      .lp_en_o      (lp_en),
      .tx_oe_o      (oe),
      .lp_tx_dp_o   (dp),
      .lp_tx_dn_o   (dn),
      .busy_o       (busy),
      .underflow_o  (uf),
      .abort_o      (ab)
   );

   typedef struct packed {
      logic [7:0] data;
      logic       hs_en, lp_en, oe, dp, dn, ready, busy, uf, ab;
   } snap_t;

   typedef struct {
      snap_t s;
      string tag;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;

   function automatic snap_t lp(input logic [1:0] l, input logic b);
      snap_t s;
      s          = '0;
      s.lp_en    = 1'b1;
      s.oe       = 1'b1;
      {s.dp, s.dn} = l;
      s.busy     = b;
      return s;
   endfunction

   function automatic snap_t hs(input logic [7:0] d, input logic r);
      snap_t s;
      s       = '0;
      s.data  = d;
      s.hs_en = 1'b1;
      s.oe    = 1'b1;
      s.ready = r;
      s.busy  = 1'b1;
      return s;
   endfunction

   task automatic push(input snap_t s, input int n, input string tag);
      exp_t e;
      e.s   = s;
      e.tag = tag;
      repeat (n) q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic l, input int n);
      valid = v;
      data  = d;
      last  = l;
      repeat (n) tick();
   endtask

   task automatic preamble();
      push(lp(2'b11, 1'b0), 1, "stop");
      push(lp(2'b01, 1'b1), P_LPX, "rqst");
      push(lp(2'b00, 1'b1), P_PREP, "prep");
      push(hs(8'h00, 1'b0), P_ZERO, "zero");
   endtask

   task automatic idle(input int n);
      push(lp(2'b11, 1'b0), n, "idle");
      drive(1'b0, 8'h00, 1'b0, n);
   endtask

   // 0x12, 0x34(last): trail 0xFF
   task automatic burst_basic();
      preamble();
      push(hs(8'hB8, 1'b1), 1, "sync");
      push(hs(8'h12, 1'b1), 1, "d0");
      push(hs(8'h34, 1'b0), 1, "d1");
      push(hs(8'hFF, 1'b0), P_TRAIL, "trail_ff");
      push(lp(2'b11, 1'b1), P_EXIT, "exit");
      drive(1'b1, 8'h12, 1'b0, 9);
      drive(1'b1, 8'h34, 1'b1, 1);
      drive(1'b0, 8'h00, 1'b0, 10);
   endtask

   task automatic burst80(input logic hold);
      preamble();
      push(hs(8'hB8, 1'b1), 1, "sync");
      push(hs(8'h80, 1'b0), 1, "d80");
      push(hs(8'h00, 1'b0), P_TRAIL, "trail_00");
      push(lp(2'b11, 1'b1), P_EXIT, "exit");
      drive(1'b1, 8'h80, 1'b1, 9);
      if (hold) drive(1'b1, 8'h80, 1'b1, 10);
      else      drive(1'b0, 8'h00, 1'b0, 10);
   endtask

   task automatic underflow_data();
      snap_t s;
      preamble();
      push(hs(8'hB8, 1'b1), 1, "sync");
      push(hs(8'h12, 1'b1), 1, "d0");
      s = hs(8'hFF, 1'b0);
      s.uf = 1'b1;
      push(s, 1, "uf_pulse");
      push(hs(8'hFF, 1'b0), P_TRAIL - 1, "uf_trail");
      push(lp(2'b11, 1'b1), P_EXIT, "exit");
      drive(1'b1, 8'h12, 1'b0, 9);
      drive(1'b0, 8'h00, 1'b0, 10);
   endtask

   task automatic underflow_sync();
      snap_t s;
      preamble();
      push(hs(8'hB8, 1'b1), 1, "sync");
      s = hs(8'h00, 1'b0);
      s.uf = 1'b1;
      push(s, 1, "uf_sync_pulse");
      push(hs(8'h00, 1'b0), P_TRAIL - 1, "uf_sync_trail");
      push(lp(2'b11, 1'b1), P_EXIT, "exit");
      drive(1'b1, 8'h12, 1'b0, 1);
      drive(1'b0, 8'h00, 1'b0, 17);
   endtask

   task automatic abort_seq();
      snap_t s;
      preamble();
      push(hs(8'hB8, 1'b1), 1, "sync");
      push(hs(8'h12, 1'b1), 1, "d0");
      s = lp(2'b11, 1'b1);
      s.ab = 1'b1;
      push(s, 1, "abort_pulse");
      push(lp(2'b11, 1'b1), P_EXIT - 1, "abort_exit");
      push(lp(2'b11, 1'b0), 6, "stop_nolock");
      drive(1'b1, 8'h12, 1'b0, 9);
      lock = 1'b0;
      drive(1'b1, 8'h34, 1'b0, 12);
      lock = 1'b1;
   endtask

   task automatic reset_mid();
      push(lp(2'b11, 1'b0), 1, "stop");
      push(lp(2'b01, 1'b1), P_LPX, "rqst");
      push(lp(2'b00, 1'b1), P_PREP, "prep");
      push(hs(8'h00, 1'b0), 2, "zero");
      drive(1'b1, 8'h12, 1'b0, 6);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      burst_basic();
   endtask

   always @(negedge clk) begin
      snap_t got;
      exp_t  e;
      cyc++;
      got = {hs_data, hs_en, lp_en, oe, dp, dn, ready, busy, uf, ab};
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (got !== e.s) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h required %h (data,hs,lp,oe,dp,dn,rdy,busy,uf,ab)",
                     e.tag, cyc, got, e.s);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      lock  = 1'b1;
      valid = 1'b1;
      last  = 1'b1;
      data  = 8'h55;
      tick();
      tick();
      push(lp(2'b11, 1'b0), 2, "reset");
      drive(1'b1, 8'h55, 1'b1, 2);
      rst_n = 1'b1;
      idle(2);

      burst_basic();
      idle(1);
      burst80(1'b0);
      idle(1);
      underflow_data();
      idle(1);
      underflow_sync();
      idle(1);
      abort_seq();
      idle(1);
      reset_mid();
      idle(1);
      burst80(1'b1);
      burst80(1'b0);
      idle(2);

      for (int i = 0; i < 10 && q.size() > 0; i++) tick();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
